// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and constants for the framebuffer pixel writer.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;

    typedef logic [2:0] color_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        color_t     color;
    } pixel_t;

    // Generic row-major address for widths without a shift-add shortcut.
    function automatic logic [FB_ADDR_W-1:0] lin_addr(
        input logic [9:0]           x,
        input logic [9:0]           y,
        input logic [FB_ADDR_W-1:0] width
    );
        return FB_ADDR_W'(y) * width + FB_ADDR_W'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : First-word-fall-through FIFO with a registered occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_writer
// Description : Clips, queues and linearises sprite pixel writes; also runs a
//               full-screen clear sequence into the video memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_writer #(
    parameter int         SCREEN_W   = fb_pkg::SCREEN_W,
    parameter int         SCREEN_H   = fb_pkg::SCREEN_H,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_pix,
    input  logic [9:0]  y_pix,
    input  logic [2:0]  color,
    input  logic        plot_in,
    output logic        ready,
    input  logic        clear_req,
    output logic        clear_busy,
    input  logic        fb_stall,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    output logic [7:0]  clip_count,
    output logic        idle
);

    import fb_pkg::*;

    localparam logic [10:0]          C_W         = 11'(SCREEN_W);
    localparam logic [10:0]          C_H         = 11'(SCREEN_H);
    localparam logic [FB_ADDR_W-1:0] C_LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    pixel_t                 w_in_px;
    pixel_t                 w_out_px;
    logic                   w_on_screen;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [FB_ADDR_W-1:0]   w_pix_addr;

    state_t                 r_state;
    logic [FB_ADDR_W-1:0]   r_clr_addr;
    logic                   r_fb_we;
    logic [FB_ADDR_W-1:0]   r_fb_addr;
    color_t                 r_fb_data;
    logic [7:0]             r_clip_count;

    state_t                 w_state_nxt;
    logic [FB_ADDR_W-1:0]   w_clr_addr_nxt;
    logic                   w_fb_we_nxt;
    logic [FB_ADDR_W-1:0]   w_fb_addr_nxt;
    color_t                 w_fb_data_nxt;
    logic                   w_load_px;

    assign w_in_px     = '{x: x_pix, y: y_pix, color: color};
    assign w_on_screen = ({1'b0, x_pix} < C_W) && ({1'b0, y_pix} < C_H);
    assign ready       = !w_full;
    assign w_accept    = plot_in && ready;
    assign w_push      = w_accept && w_on_screen;

    pixel_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_in_px),
        .o_dout  (w_out_px),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    generate
        if (SCREEN_W == 320) begin : g_addr_shift
            // 320 = 256 + 64, so the multiply collapses to two shifts and adds.
            assign w_pix_addr = (FB_ADDR_W'(w_out_px.y) << 8)
                              + (FB_ADDR_W'(w_out_px.y) << 6)
                              + FB_ADDR_W'(w_out_px.x);
        end else begin : g_addr_mul
            assign w_pix_addr = lin_addr(w_out_px.x, w_out_px.y, FB_ADDR_W'(SCREEN_W));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_count <= '0;
        end else if (w_accept && !w_on_screen && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_fb_we_nxt    = r_fb_we;
        w_fb_addr_nxt  = r_fb_addr;
        w_fb_data_nxt  = r_fb_data;
        w_load_px      = 1'b0;
        w_pop          = 1'b0;

        // A stall freezes the whole output stage and the sequencer.
        if (!fb_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        w_state_nxt    = ST_CLEAR;
                        w_clr_addr_nxt = '0;
                        w_fb_we_nxt    = 1'b1;
                        w_fb_addr_nxt  = '0;
                        w_fb_data_nxt  = BG_COLOR;
                    end else begin
                        w_load_px = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_addr == C_LAST_ADDR) begin
                        w_state_nxt    = ST_IDLE;
                        w_clr_addr_nxt = '0;
                        w_load_px      = 1'b1;
                    end else begin
                        w_clr_addr_nxt = r_clr_addr + 1'b1;
                        w_fb_we_nxt    = 1'b1;
                        w_fb_addr_nxt  = r_clr_addr + 1'b1;
                        w_fb_data_nxt  = BG_COLOR;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_load_px) begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = w_pix_addr;
                    w_fb_data_nxt = w_out_px.color;
                end else begin
                    w_fb_we_nxt   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_fb_we    <= w_fb_we_nxt;
            r_fb_addr  <= w_fb_addr_nxt;
            r_fb_data  <= w_fb_data_nxt;
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign clip_count = r_clip_count;
    assign clear_busy = (r_state == ST_CLEAR);
    assign idle       = (r_state == ST_IDLE) && w_empty && !r_fb_we;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_writer
// Description : Scoreboard bench: a reference model predicts the write stream,
//               a negedge monitor compares every write the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_writer;

    localparam int         W    = 320;
    localparam int         H    = 240;
    localparam int         NPIX = W * H;
    localparam logic [2:0] BG   = 3'b000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_pix = '0;
    logic [9:0]  y_pix = '0;
    logic [2:0]  color = '0;
    logic        plot_in = 1'b0;
    logic        clear_req = 1'b0;
    logic        fb_stall = 1'b0;
    logic        ready;
    logic        clear_busy;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic [7:0]  clip_count;
    logic        idle;

    always #5 clk = ~clk;

    framebuffer_writer #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .FIFO_DEPTH (8),
        .BG_COLOR   (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_pix      (x_pix),
        .y_pix      (y_pix),
        .color      (color),
        .plot_in    (plot_in),
        .ready      (ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .fb_stall   (fb_stall),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .clip_count (clip_count),
        .idle       (idle)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_clear = 1'b0;
    bit          was_clear;
    int unsigned m_cidx = 0;
    int unsigned m_clip = 0;
    bit          prev_valid = 1'b0;
    bit          prev_stall = 1'b0;
    logic [20:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard / reference model, evaluated once per cycle on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_clear    = 1'b0;
            m_cidx     = 0;
            m_clip     = 0;
            prev_valid = 1'b0;
            chk("reset_state", {fb_we, clear_busy, ready, idle, fb_data, fb_addr, clip_count},
                {1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 17'd0, 8'd0});
        end else begin
            was_clear = m_clear;
            chk("clip_count", clip_count, m_clip);
            chk("clear_busy", clear_busy, m_clear);
            chk("idle", idle, (!m_clear && exp_q.size() == 0));
            if (prev_valid && prev_stall)
                chk("stall_hold", {fb_we, fb_addr, fb_data}, prev_out);

            if (!fb_stall) begin
                if (m_clear) begin
                    chk("clear_we", fb_we, 1);
                    if (fb_we) begin
                        chk("clear_addr", fb_addr, m_cidx);
                        chk("clear_data", fb_data, BG);
                        m_cidx++;
                        if (m_cidx == NPIX) m_clear = 1'b0;
                    end
                end else if (fb_we) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_write: got addr %0d data %0d, required no write",
                                 fb_addr, fb_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("px_addr", fb_addr, e.addr);
                        chk("px_data", fb_data, e.data);
                    end
                end
                if (!was_clear && clear_req) begin
                    m_clear = 1'b1;
                    m_cidx  = 0;
                end
            end

            if (plot_in && ready) begin
                if (x_pix < W && y_pix < H)
                    exp_q.push_back('{addr: y_pix * W + x_pix, data: color});
                else if (m_clip < 255)
                    m_clip++;
            end

            prev_valid = 1'b1;
            prev_stall = fb_stall;
            prev_out   = {fb_we, fb_addr, fb_data};
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic plot1(input int x, input int y, input int c);
        int g = 0;
        while (!ready && g < 200) begin
            step(1);
            g++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL plot_ready_timeout: got ready 0, required 1");
        end
        x_pix   = 10'(x);
        y_pix   = 10'(y);
        color   = 3'(c);
        plot_in = 1'b1;
        step(1);
        plot_in = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int g = 0;
        while ((exp_q.size() != 0 || m_clear) && g < budget) begin
            step(1);
            g++;
        end
        step(2);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin : stim
        int acc;
        bit rb;
        int run;
        int g;
        int len;
        int stall_left;
        bit stalled_once;

        step(3);
        reset = 1'b0;
        step(2);

        // Single pixel and its two-cycle latency.
        x_pix = 10'd5; y_pix = 10'd3; color = 3'b101; plot_in = 1'b1;
        step(1);
        plot_in = 1'b0;
        chk("lat_early_we", fb_we, 0);
        step(1);
        chk("lat_we", fb_we, 1);
        chk("lat_addr", fb_addr, 965);
        chk("lat_data", fb_data, 5);
        step(1);
        chk("lat_idle", idle, 1);

        // Corners and clipping.
        plot1(0, 0, 1);
        plot1(319, 239, 6);
        plot1(320, 0, 2);
        plot1(0, 240, 3);
        wait_quiet(50);
        chk("clip_two", clip_count, 2);

        // Saturation of the clip counter.
        x_pix = 10'd700; y_pix = 10'd10; plot_in = 1'b1;
        step(260);
        plot_in = 1'b0;
        step(1);
        chk("clip_sat", clip_count, 255);

        // Backpressure: FIFO fills while the memory port is stalled.
        fb_stall = 1'b1;
        acc = 0;
        x_pix = 10'd10; y_pix = 10'd20; color = 3'd0; plot_in = 1'b1;
        repeat (12) begin
            rb = ready;
            step(1);
            if (rb) begin
                acc++;
                x_pix = 10'(10 + acc);
                color = 3'(acc);
            end
        end
        chk("bp_accepts", acc, 8);
        chk("bp_ready_low", ready, 0);
        plot_in  = 1'b0;
        fb_stall = 1'b0;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (fb_we) run++;
        end
        chk("bp_burst", run, 8);
        step(1);
        chk("bp_burst_end", fb_we, 0);
        plot1(18, 20, 0);
        plot1(19, 20, 1);
        wait_quiet(50);

        // Randomised traffic with random stalls.
        for (int i = 0; i < 1500; i++) begin
            plot_in  = 1'($urandom_range(0, 1));
            x_pix    = 10'($urandom_range(0, 340));
            y_pix    = 10'($urandom_range(0, 255));
            color    = 3'($urandom);
            fb_stall = ($urandom_range(0, 3) == 0);
            step(1);
        end
        plot_in  = 1'b0;
        fb_stall = 1'b0;
        wait_quiet(100);

        // Reset in the middle of a clear with pixels queued.
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x_pix = 10'(50 + k); y_pix = 10'd60; color = 3'(k + 1); plot_in = 1'b1;
            step(1);
        end
        plot_in = 1'b0;
        g = 0;
        while (!(clear_busy && fb_addr == 17'd5000) && g < 6000) begin
            step(1);
            g++;
        end
        chk("rst_reach_5000", fb_addr, 5000);
        reset = 1'b1;
        #1;
        chk("rst_async", {fb_we, clear_busy, ready, idle}, 4'b0011);
        step(2);
        reset = 1'b0;
        run = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (fb_we) run++;
        end
        chk("rst_no_writes", run, 0);

        // Full clear with a pixel plotted mid-clear and a 3-cycle stall at 100.
        clear_req = 1'b1;
        step(1);
        clear_req    = 1'b0;
        len          = 0;
        stall_left   = 0;
        stalled_once = 1'b0;
        while (clear_busy === 1'b1 && len < 80000) begin
            len++;
            plot_in = (len == 10);
            x_pix = 10'd5; y_pix = 10'd3; color = 3'b101;
            if (fb_addr == 17'd100 && !stalled_once) begin
                stall_left   = 3;
                stalled_once = 1'b1;
            end
            fb_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            step(1);
        end
        plot_in  = 1'b0;
        fb_stall = 1'b0;
        chk("clear_len", len, NPIX + 3);
        wait_quiet(50);
        chk("final_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
